hc595_chain_driver: RTL

//  Serialises a parallel word onto a daisy-chain of N_CHIPS 74HC595 SIPO shift registers.

---
 rtl/hc595_chain_driver.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/hc595_chain_driver.sv
// Serialises a W = 8*N_CHIPS word MSB-first onto a cascaded 74HC595 chain, then latches it.
// Optional shift-register clear request is built in when HC595_DRV_CLEAR_EN is defined.
module hc595_chain_driver #(
    parameter int N_CHIPS = 1,
    parameter int CLK_DIV = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*N_CHIPS-1:0]   din,
    input  logic                   valid,
    output logic                   ready,
    input  logic                   clr_req,
    input  logic                   oe_en,
    output logic                   done,
    output logic                   SER,
    output logic                   SRCLK,
    output logic                   RCLK,
    output logic                   SRCLR_n,
    output logic                   OE_n
);

    localparam int W  = 8 * N_CHIPS;
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int CW = $clog2(W);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_TOP  = CW'(W - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH_LO,
        LATCH_HI,
        CLEAR
    } state_t;

    state_t          state;
    logic [W-1:0]    shadow;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nx;
    logic [DW-1:0]   div;
    logic            div_end;

    always_comb begin
        cnt_nx  = cnt - CW'(1);
        div_end = (div == '0);
    end

`ifdef HC595_DRV_CLEAR_EN
    assign ready = (state == IDLE) && !clr_req;
`else
    logic unused_clr_req;
    assign unused_clr_req = clr_req;
    assign ready = (state == IDLE);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            shadow  <= '0;
            cnt     <= '0;
            div     <= '0;
            SER     <= 1'b0;
            SRCLK   <= 1'b0;
            RCLK    <= 1'b0;
            SRCLR_n <= 1'b0;
            OE_n    <= 1'b1;
            done    <= 1'b0;
        end else begin
            OE_n    <= ~oe_en;
            done    <= 1'b0;
            SRCLR_n <= 1'b1;

            case (state)
                IDLE: begin
`ifdef HC595_DRV_CLEAR_EN
                    if (clr_req) begin
                        SRCLR_n <= 1'b0;
                        div     <= DIV_LAST;
                        state   <= CLEAR;
                    end else
`endif
                    if (valid) begin
                        shadow <= din;
                        cnt    <= CNT_TOP;
                        div    <= DIV_LAST;
                        SER    <= din[W-1];
                        SRCLK  <= 1'b0;
                        state  <= SHIFT_LO;
                    end
                end

                SHIFT_LO: begin
                    if (div_end) begin
                        div   <= DIV_LAST;
                        SRCLK <= 1'b1;
                        state <= SHIFT_HI;
                    end else begin
                        div <= div - DW'(1);
                    end
                end

                SHIFT_HI: begin
                    if (div_end) begin
                        div   <= DIV_LAST;
                        SRCLK <= 1'b0;
                        if (cnt == '0) begin
                            state <= LATCH_LO;
                        end else begin
                            // next data bit is set up together with the falling SRCLK
                            cnt   <= cnt_nx;
                            SER   <= shadow[cnt_nx];
                            state <= SHIFT_LO;
                        end
                    end else begin
                        div <= div - DW'(1);
                    end
                end

                LATCH_LO: begin
                    if (div_end) begin
                        div   <= DIV_LAST;
                        RCLK  <= 1'b1;
                        state <= LATCH_HI;
                    end else begin
                        div <= div - DW'(1);
                    end
                end

                LATCH_HI: begin
                    if (div_end) begin
                        RCLK  <= 1'b0;
                        SER   <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        div <= div - DW'(1);
                    end
                end

                CLEAR: begin
                    if (div_end) begin
                        state <= IDLE;
                    end else begin
                        SRCLR_n <= 1'b0;
                        div     <= div - DW'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
